egg_timer_load_counter: RTL and testbench
=========================================

Name: egg_timer_load_counter

Overview:
- Cook-time entry stage of the egg timer.
- While `cook_time` (load mode) is high, debounced presses of `minutes_up` and `seconds_up` step a 4-digit BCD MM:SS value.
- `start` with a nonzero loaded time asserts `enable_timer_cooktime`, which hands the loaded value to the downstream countdown stage.
- Debounced button levels are exported for display and diagnostics.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required before a debounced output changes (raise for silicon; keep 4 for simulation).
- MINUTE_MAX, 99, highest minute value before wrap to 00.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  raw start button, level.
- cook_time  input  1  load-mode enable, level.
- minutes_up  input  1  raw minutes increment button.
- seconds_up  input  1  raw seconds increment button.
- enable_timer_cooktime  output  1  loaded time valid; countdown may run.
- second_ones  output  4  BCD seconds units, 0-9.
- second_tens  output  4  BCD seconds tens, 0-5.
- minute_ones  output  4  BCD minutes units, 0-9.
- minute_tens  output  4  BCD minutes tens, 0-9.
- debounce_min  output  1  debounced `minutes_up` level.
- debounce_sec  output  1  debounced `seconds_up` level.

Behaviour:
- Reset (`reset` low, asynchronous): all digits 0, `enable_timer_cooktime` 0, `debounce_min`/`debounce_sec` 0, synchronizers and counters cleared.
- All state registered on the `clk` rising edge.
- Debounce, per button:
  - 2-FF synchronizer.
  - Stability counter: while the synchronized value differs from the debounced output, the counter increments; otherwise it clears.
  - The output takes the new value when the counter reaches DEBOUNCE_CYCLES.
  - The debounced output therefore changes exactly DEBOUNCE_CYCLES+2 rising edges after a clean input transition.
  - Glitches shorter than DEBOUNCE_CYCLES are rejected.
- Increment event: a rising edge of a debounced level, detected with a 1-cycle delay register. Exactly one step per press; no auto-repeat while held.
- Digits update on the edge after the debounced rise, only if `cook_time`=1 and `enable_timer_cooktime`=0. Otherwise the event is discarded, not queued.
- Seconds step: 00→59 BCD, then 59→00. No carry into minutes.
- Minutes step: 00→MINUTE_MAX BCD, then MINUTE_MAX→00.
- Simultaneous minute and second events in the same cycle: both applied in that cycle.
- Start:
  - `enable_timer_cooktime` sets on the first edge where `start`=1, `cook_time`=0, and the loaded time is not 00:00.
  - `start` with `cook_time`=1 or time 00:00 is ignored.
  - Once set, it stays high until reset, and the digits are frozen.
- `start` is level-sampled and not debounced; holding it is harmless.
- Reset mid-load or mid-run: immediate return to reset state regardless of inputs.
- Outputs are registers; no combinational input→output paths.

Decomposition:
- Shared package: BCD digit width (4), seconds tens limit (5), default DEBOUNCE_CYCLES.
- One sub-module, `button_debounce`: synchronizer, stability counter, debounced level output. Instantiated twice.
- The BCD stepping and start control stay in the top block.

Test Plan:
- Reset pulse low then high → all digits 0, `enable_timer_cooktime`=0, both debounce outputs 0.
- `cook_time`=1, `minutes_up` held 14 cycles → `debounce_min` rises 6 cycles after the input rise; `minute_ones`=1 one cycle later; no further increment while held; `debounce_min` falls 6 cycles after release.
- 60 debounced `seconds_up` presses in load mode → 01..59 then 00; `second_tens` never exceeds 5; minutes unchanged.
- 3-cycle `minutes_up` glitch → `debounce_min` stays 0, digits unchanged. Press with `cook_time`=0 → `debounce_min` toggles, digits unchanged.
- Load 01:01, `cook_time`=0, `start`=1 → `enable_timer_cooktime`=1 next edge. Subsequent presses with `cook_time`=1 leave digits 01:01.
- `start` at 00:00 → `enable_timer_cooktime` stays 0. Then, with `enable_timer_cooktime` high from a prior valid start, `reset` driven low asynchronously → all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/egg_timer_load_counter_pkg.sv
// Shared constants and BCD helper for the egg timer cook-time entry stage.
package egg_timer_load_counter_pkg;

   localparam int BCD_W               = 4;
   localparam int SEC_TENS_MAX        = 5;
   localparam int DEBOUNCE_CYCLES_DEF = 4;

   typedef logic [BCD_W-1:0] bcd_t;

   // Advance a two-digit BCD value by one, wrapping to 00 after {tensMax, onesMax}.
   function automatic logic [2*BCD_W-1:0] bcdStep(input bcd_t tens, input bcd_t ones,
                                                  input bcd_t tensMax, input bcd_t onesMax);
      logic [2*BCD_W-1:0] result;
      if (tens == tensMax && ones == onesMax) begin
         result = '0;
      end else if (ones == bcd_t'(9)) begin
         result = {bcd_t'(tens + bcd_t'(1)), bcd_t'(0)};
      end else begin
         result = {tens, bcd_t'(ones + bcd_t'(1))};
      end
      return result;
   endfunction

endpackage

// File: rtl/egg_timer_load_counter_button_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output follows the
// synchronized level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module button_debounce
   import egg_timer_load_counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button_i,
   output logic level_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Any cycle where the synchronized level agrees with the output restarts the count.
   always_comb begin
      count_d = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (count_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         count_q <= '0;
      end else begin
         sync1_q <= button_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         count_q <= count_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/egg_timer_load_counter.sv
// Cook-time entry: debounced buttons step a BCD MM:SS value in load mode, and a
// valid start freezes it and hands it on to the countdown stage.
module egg_timer_load_counter
   import egg_timer_load_counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int MINUTE_MAX      = 99
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             cook_time,
   input  logic             minutes_up,
   input  logic             seconds_up,
   output logic             enable_timer_cooktime,
   output logic [BCD_W-1:0] second_ones,
   output logic [BCD_W-1:0] second_tens,
   output logic [BCD_W-1:0] minute_ones,
   output logic [BCD_W-1:0] minute_tens,
   output logic             debounce_min,
   output logic             debounce_sec
);

   localparam bcd_t MIN_TENS_MAX = bcd_t'(MINUTE_MAX / 10);
   localparam bcd_t MIN_ONES_MAX = bcd_t'(MINUTE_MAX % 10);
   localparam bcd_t SEC_TENS_LIM = bcd_t'(SEC_TENS_MAX);
   localparam bcd_t SEC_ONES_LIM = bcd_t'(9);

   logic debMin;
   logic debSec;
   logic debMinPrev_q;
   logic debSecPrev_q;
   logic minEvent;
   logic secEvent;
   logic loadAllowed;
   logic timeZero;
   logic enable_q;
   logic enable_d;
   bcd_t minTens_q, minTens_d;
   bcd_t minOnes_q, minOnes_d;
   bcd_t secTens_q, secTens_d;
   bcd_t secOnes_q, secOnes_d;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uMinDebounce (
      .clk      (clk),
      .rst_n    (reset),
      .button_i (minutes_up),
      .level_o  (debMin)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uSecDebounce (
      .clk      (clk),
      .rst_n    (reset),
      .button_i (seconds_up),
      .level_o  (debSec)
   );

   // Press events are one-cycle pulses; events outside load mode are simply dropped.
   always_comb begin
      minTens_d   = minTens_q;
      minOnes_d   = minOnes_q;
      secTens_d   = secTens_q;
      secOnes_d   = secOnes_q;
      enable_d    = enable_q;
      minEvent    = debMin & ~debMinPrev_q;
      secEvent    = debSec & ~debSecPrev_q;
      loadAllowed = cook_time & ~enable_q;
      timeZero    = (minTens_q == '0) && (minOnes_q == '0) &&
                    (secTens_q == '0) && (secOnes_q == '0);
      if (loadAllowed && minEvent) begin
         {minTens_d, minOnes_d} = bcdStep(minTens_q, minOnes_q, MIN_TENS_MAX, MIN_ONES_MAX);
      end
      if (loadAllowed && secEvent) begin
         {secTens_d, secOnes_d} = bcdStep(secTens_q, secOnes_q, SEC_TENS_LIM, SEC_ONES_LIM);
      end
      if (start && !cook_time && !timeZero) begin
         enable_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         debMinPrev_q <= 1'b0;
         debSecPrev_q <= 1'b0;
         enable_q     <= 1'b0;
         minTens_q    <= '0;
         minOnes_q    <= '0;
         secTens_q    <= '0;
         secOnes_q    <= '0;
      end else begin
         debMinPrev_q <= debMin;
         debSecPrev_q <= debSec;
         enable_q     <= enable_d;
         minTens_q    <= minTens_d;
         minOnes_q    <= minOnes_d;
         secTens_q    <= secTens_d;
         secOnes_q    <= secOnes_d;
      end
   end

   assign enable_timer_cooktime = enable_q;
   assign minute_tens           = minTens_q;
   assign minute_ones           = minOnes_q;
   assign second_tens           = secTens_q;
   assign second_ones           = secOnes_q;
   assign debounce_min          = debMin;
   assign debounce_sec          = debSec;

endmodule

// File: tb/tb_egg_timer_load_counter.sv
// Self-checking bench: hand-computed vector table, wrap/start/reset sequences,
// and randomized button activity compared against an integer-level reference model.
module tb_egg_timer_load_counter;

   localparam int DEB     = 4;
   localparam int MIN_MAX = 99;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       cookTime = 1'b0;
   logic       minutesUp = 1'b0;
   logic       secondsUp = 1'b0;
   logic       enableTimer;
   logic [3:0] secondOnes, secondTens, minuteOnes, minuteTens;
   logic       debounceMin, debounceSec;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct {
      bit          st;
      bit          ck;
      bit          mu;
      bit          su;
      int          hold;
      logic [18:0] expOut;
      string       name;
   } vec_t;

   vec_t vecs[$];

   // Reference model state: plain integers for time, per-button sample history.
   bit mSync1[2], mSync2[2], mDeb[2], mDebPrev[2];
   int mRun[2];
   int mSecs, mMins;
   bit mEn;

   egg_timer_load_counter #(.DEBOUNCE_CYCLES(DEB), .MINUTE_MAX(MIN_MAX)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .start                 (start),
      .cook_time             (cookTime),
      .minutes_up            (minutesUp),
      .seconds_up            (secondsUp),
      .enable_timer_cooktime (enableTimer),
      .second_ones           (secondOnes),
      .second_tens           (secondTens),
      .minute_ones           (minuteOnes),
      .minute_tens           (minuteTens),
      .debounce_min          (debounceMin),
      .debounce_sec          (debounceSec)
   );

   always #5 clk = ~clk;

   function automatic logic [18:0] mkOut(input bit en, input int mins, input int secs,
                                         input bit dm, input bit ds);
      logic [3:0] mt, mo, st, so;
      mt = 4'(mins / 10);
      mo = 4'(mins % 10);
      st = 4'(secs / 10);
      so = 4'(secs % 10);
      return {en, mt, mo, st, so, dm, ds};
   endfunction

   function automatic logic [18:0] dutOut();
      return {enableTimer, minuteTens, minuteOnes, secondTens, secondOnes, debounceMin, debounceSec};
   endfunction

   task automatic addVec(input bit st, input bit ck, input bit mu, input bit su, input int hold,
                         input logic [18:0] expOut, input string name);
      vec_t v;
      v.st = st; v.ck = ck; v.mu = mu; v.su = su; v.hold = hold; v.expOut = expOut; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic checkOutput(input string name, input logic [18:0] expOut);
      logic [18:0] got;
      got = dutOut();
      testsRun++;
      if (got !== expOut) begin
         testsFailed++;
         $display("[TB] FAIL %s at %0t: got en=%0b %h%h:%h%h dm=%0b ds=%0b, expected en=%0b %h%h:%h%h dm=%0b ds=%0b",
                  name, $time, got[18], got[17:14], got[13:10], got[9:6], got[5:2], got[1], got[0],
                  expOut[18], expOut[17:14], expOut[13:10], expOut[9:6], expOut[5:2], expOut[1], expOut[0]);
      end
   endtask

   task automatic modelReset();
      for (int b = 0; b < 2; b++) begin
         mSync1[b] = 0; mSync2[b] = 0; mDeb[b] = 0; mDebPrev[b] = 0; mRun[b] = 0;
      end
      mSecs = 0; mMins = 0; mEn = 0;
   endtask

   // One rising edge of the model, using the input levels held before that edge.
   task automatic modelEdge();
      bit raw[2];
      bit ev[2];
      bit nonZero;
      raw[0] = minutesUp;
      raw[1] = secondsUp;
      for (int b = 0; b < 2; b++) ev[b] = mDeb[b] && !mDebPrev[b];
      nonZero = (mSecs != 0) || (mMins != 0);
      if (cookTime && !mEn) begin
         if (ev[0]) mMins = (mMins + 1) % (MIN_MAX + 1);
         if (ev[1]) mSecs = (mSecs + 1) % 60;
      end
      if (start && !cookTime && nonZero) mEn = 1;
      for (int b = 0; b < 2; b++) begin
         mDebPrev[b] = mDeb[b];
         if (mSync2[b] != mDeb[b]) begin
            mRun[b]++;
            if (mRun[b] == DEB) begin
               mDeb[b] = mSync2[b];
               mRun[b] = 0;
            end
         end else begin
            mRun[b] = 0;
         end
         mSync2[b] = mSync1[b];
         mSync1[b] = raw[b];
      end
   endtask

   task automatic step(input bit chk);
      @(posedge clk);
      modelEdge();
      #1;
      if (chk) checkOutput("randomVsModel", mkOut(mEn, mMins, mSecs, mDeb[0], mDeb[1]));
   endtask

   task automatic applyStimulus(input bit st, input bit ck, input bit mu, input bit su, input int hold);
      start = st; cookTime = ck; minutesUp = mu; secondsUp = su;
      repeat (hold) step(1'b0);
   endtask

   task automatic doReset();
      reset = 1'b0;
      #2;
      modelReset();
      checkOutput("resetState", '0);
      reset = 1'b1;
   endtask

   initial begin
      // Expected values worked out by hand from the debounce and load rules.
      addVec(0, 1, 1, 0, 5, mkOut(0, 0, 0, 0, 0), "minHeldBeforeDebounce");
      addVec(0, 1, 1, 0, 1, mkOut(0, 0, 0, 1, 0), "minDebounceRise");
      addVec(0, 1, 1, 0, 1, mkOut(0, 1, 0, 1, 0), "minIncrement");
      addVec(0, 1, 1, 0, 7, mkOut(0, 1, 0, 1, 0), "minHeldNoRepeat");
      addVec(0, 1, 0, 0, 5, mkOut(0, 1, 0, 1, 0), "minReleaseBeforeFall");
      addVec(0, 1, 0, 0, 1, mkOut(0, 1, 0, 0, 0), "minDebounceFall");
      addVec(0, 1, 0, 1, 7, mkOut(0, 1, 1, 0, 1), "secPress");
      addVec(0, 1, 0, 0, 6, mkOut(0, 1, 1, 0, 0), "secRelease");
      addVec(0, 1, 1, 0, 3, mkOut(0, 1, 1, 0, 0), "glitchHigh");
      addVec(0, 1, 0, 0, 8, mkOut(0, 1, 1, 0, 0), "glitchRejected");
      addVec(0, 0, 1, 0, 7, mkOut(0, 1, 1, 1, 0), "pressOutsideLoad");
      addVec(0, 0, 0, 0, 6, mkOut(0, 1, 1, 0, 0), "releaseOutsideLoad");
      addVec(0, 1, 1, 1, 7, mkOut(0, 2, 2, 1, 1), "simultaneousPress");
      addVec(0, 1, 0, 0, 6, mkOut(0, 2, 2, 0, 0), "simultaneousRelease");
      addVec(1, 1, 0, 0, 2, mkOut(0, 2, 2, 0, 0), "startInLoadIgnored");
      addVec(1, 0, 0, 0, 1, mkOut(1, 2, 2, 0, 0), "startValid");
      addVec(0, 1, 1, 1, 7, mkOut(1, 2, 2, 1, 1), "frozenPress");
      addVec(0, 1, 0, 0, 6, mkOut(1, 2, 2, 0, 0), "frozenRelease");
      addVec(1, 0, 0, 0, 3, mkOut(1, 2, 2, 0, 0), "startHeld");

      doReset();
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].st, vecs[i].ck, vecs[i].mu, vecs[i].su, vecs[i].hold);
         checkOutput(vecs[i].name, vecs[i].expOut);
      end

      // Seconds walk through 01..59 and wrap to 00 without touching minutes.
      doReset();
      for (int i = 1; i <= 60; i++) begin
         applyStimulus(0, 1, 0, 1, 7);
         applyStimulus(0, 1, 0, 0, 6);
         checkOutput($sformatf("secStep%0d", i), mkOut(0, 0, i % 60, 0, 0));
      end

      // Minutes walk through 01..99 and wrap to 00.
      for (int i = 1; i <= MIN_MAX + 1; i++) begin
         applyStimulus(0, 1, 1, 0, 7);
         applyStimulus(0, 1, 0, 0, 6);
         if (i % 10 == 0 || i >= MIN_MAX - 1)
            checkOutput($sformatf("minStep%0d", i), mkOut(0, i % (MIN_MAX + 1), 0, 0, 0));
      end

      // Start at 00:00 is ignored; a valid start is then cut off by an asynchronous reset.
      doReset();
      applyStimulus(1, 0, 0, 0, 3);
      checkOutput("startAtZero", mkOut(0, 0, 0, 0, 0));
      applyStimulus(0, 1, 1, 1, 7);
      applyStimulus(0, 1, 0, 0, 6);
      checkOutput("load0101", mkOut(0, 1, 1, 0, 0));
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("startEnables", mkOut(1, 1, 1, 0, 0));
      applyStimulus(1, 0, 1, 1, 6);
      checkOutput("beforeAsyncReset", mkOut(1, 1, 1, 1, 1));
      #3;
      reset = 1'b0;
      #1;
      checkOutput("asyncReset", '0);
      modelReset();
      start = 0; cookTime = 0; minutesUp = 0; secondsUp = 0;
      #1;
      reset = 1'b1;

      // Random button activity against the reference model.
      doReset();
      cookTime = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 7) == 0) minutesUp = ~minutesUp;
         if ($urandom_range(0, 7) == 0) secondsUp = ~secondsUp;
         if ($urandom_range(0, 24) == 0) cookTime = ~cookTime;
         start = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 399) == 0) begin
            doReset();
         end else begin
            step(1'b1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
